// File: rtl/ikaopm_dac.sv
// Serial floating-point to linear PCM converter for the OPM sound output.
// Captures 13-bit words on sample-hold falling edges and produces R/L/mono samples with strobes.
module ikaopm_dac #(
  parameter int STROBE_LEN = 1
) (
  input  logic        i_EMUCLK,
  input  logic        i_MRST_n,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_SO,
  input  logic        i_SH1,
  input  logic        i_SH2,
  input  logic        i_SEQ_CLR,
  output logic [15:0] o_R,
  output logic [15:0] o_L,
  output logic [15:0] o_MONO,
  output logic        o_R_VALID,
  output logic        o_L_VALID,
  output logic        o_SEQ_ERR
);

  localparam logic [3:0] STROBE_CNT = 4'(STROBE_LEN);

  localparam logic [1:0] LAST_NONE = 2'd0;
  localparam logic [1:0] LAST_R    = 2'd1;
  localparam logic [1:0] LAST_L    = 2'd2;

  logic [12:0] sr_q;
  logic        sh1_q, sh2_q;
  logic [12:0] word_r_q, word_l_q;
  logic        pend_r_q, pend_l_q;
  logic [15:0] r_q, l_q, mono_q;
  logic [15:0] r_d, l_d, mono_d;
  logic [3:0]  cnt_r_q, cnt_l_q;
  logic [3:0]  cnt_r_d, cnt_l_d;
  logic [1:0]  last_q, last_d;
  logic        err_q, err_d;

  logic        en;
  logic        fall_r, fall_l;
  logic        set_err;
  logic [16:0] sum;

  // Exponent 0 is silence; otherwise the 10-bit offset-binary value is scaled by 2^(e-1).
  function automatic logic [15:0] conv(input logic [12:0] w);
    logic [2:0]  e;
    logic [15:0] t16;
    e   = w[12:10];
    t16 = {{6{~w[9]}}, ~w[9], w[8:0]};
    if (e == 3'd0) conv = 16'd0;
    else           conv = t16 << (e - 3'd1);
  endfunction

  always_comb begin
    en     = ~i_phi1_NCEN_n;
    fall_r = en & sh1_q & ~i_SH1;
    fall_l = en & sh2_q & ~i_SH2;
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      sr_q     <= '0;
      sh1_q    <= 1'b0;
      sh2_q    <= 1'b0;
      word_r_q <= '0;
      word_l_q <= '0;
      pend_r_q <= 1'b0;
      pend_l_q <= 1'b0;
    end else begin
      if (en) begin
        sr_q  <= {i_SO, sr_q[12:1]};
        sh1_q <= i_SH1;
        sh2_q <= i_SH2;
      end
      // The word is taken before this cycle's shift lands.
      if (fall_r) word_r_q <= sr_q;
      if (fall_l) word_l_q <= sr_q;
      pend_r_q <= fall_r;
      pend_l_q <= fall_l;
    end
  end

  always_comb begin
    r_d     = pend_r_q ? conv(word_r_q) : r_q;
    l_d     = pend_l_q ? conv(word_l_q) : l_q;
    sum     = {r_d[15], r_d} + {l_d[15], l_d};
    mono_d  = (pend_r_q | pend_l_q) ? sum[16:1] : mono_q;
    cnt_r_d = pend_r_q ? STROBE_CNT : ((cnt_r_q != 4'd0) ? cnt_r_q - 4'd1 : 4'd0);
    cnt_l_d = pend_l_q ? STROBE_CNT : ((cnt_l_q != 4'd0) ? cnt_l_q - 4'd1 : 4'd0);
  end

  always_comb begin
    last_d  = last_q;
    set_err = 1'b0;
    if (fall_r && fall_l) begin
      last_d = LAST_NONE;
    end else if (fall_r) begin
      set_err = (last_q == LAST_R);
      last_d  = LAST_R;
    end else if (fall_l) begin
      set_err = (last_q == LAST_L);
      last_d  = LAST_L;
    end
    // Setting has priority over the clear request.
    err_d = set_err ? 1'b1 : (i_SEQ_CLR ? 1'b0 : err_q);
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      r_q     <= '0;
      l_q     <= '0;
      mono_q  <= '0;
      cnt_r_q <= '0;
      cnt_l_q <= '0;
      last_q  <= LAST_NONE;
      err_q   <= 1'b0;
    end else begin
      r_q     <= r_d;
      l_q     <= l_d;
      mono_q  <= mono_d;
      cnt_r_q <= cnt_r_d;
      cnt_l_q <= cnt_l_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    o_R       = r_q;
    o_L       = l_q;
    o_MONO    = mono_q;
    o_R_VALID = (cnt_r_q != 4'd0);
    o_L_VALID = (cnt_l_q != 4'd0);
    o_SEQ_ERR = err_q;
  end

endmodule

// File: tb/tb_ikaopm_dac.sv
// Directed bench for ikaopm_dac: serial words, channel outputs, mono, strobes, order error, freeze and reset.
module tb_ikaopm_dac;

  logic        clk;
  logic        rst_n;
  logic        ncen_n;
  logic        so;
  logic        sh1, sh2;
  logic        seq_clr;
  logic [15:0] o_r, o_l, o_mono;
  logic        r_valid, l_valid, seq_err;

  int checks = 0;
  int errors = 0;

  ikaopm_dac #(.STROBE_LEN(1)) dut (
    .i_EMUCLK      (clk),
    .i_MRST_n      (rst_n),
    .i_phi1_NCEN_n (ncen_n),
    .i_SO          (so),
    .i_SH1         (sh1),
    .i_SH2         (sh2),
    .i_SEQ_CLR     (seq_clr),
    .o_R           (o_r),
    .o_L           (o_l),
    .o_MONO        (o_mono),
    .o_R_VALID     (r_valid),
    .o_L_VALID     (l_valid),
    .o_SEQ_ERR     (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One active edge; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [12:0] w, input logic use_r, input logic use_l);
    for (int i = 0; i < 13; i++) begin
      so = w[i];
      if (use_r) sh1 = 1'b1;
      if (use_l) sh2 = 1'b1;
      tick();
    end
  endtask

  // Falling strobe edge, then the update edge.
  task automatic fall_and_update(input logic use_r, input logic use_l);
    so = 1'b0;
    if (use_r) sh1 = 1'b0;
    if (use_l) sh2 = 1'b0;
    tick();
    if (use_r) check("r_valid_before_update", int'(r_valid), 0);
    if (use_l) check("l_valid_before_update", int'(l_valid), 0);
    tick();
  endtask

  task automatic send_word(input logic [12:0] w, input logic use_r, input logic use_l);
    send_bits(w, use_r, use_l);
    fall_and_update(use_r, use_l);
  endtask

  initial begin
    rst_n   = 1'b0;
    ncen_n  = 1'b0;
    so      = 1'b0;
    sh1     = 1'b0;
    sh2     = 1'b0;
    seq_clr = 1'b0;
    tick();
    tick();
    check("reset_r",       int'($signed(o_r)), 0);
    check("reset_l",       int'($signed(o_l)), 0);
    check("reset_mono",    int'($signed(o_mono)), 0);
    check("reset_r_valid", int'(r_valid), 0);
    check("reset_l_valid", int'(l_valid), 0);
    check("reset_seq_err", int'(seq_err), 0);
    rst_n = 1'b1;
    tick();

    // Largest positive value on R.
    send_word(13'h1FFF, 1'b1, 1'b0);
    check("r_max",         int'($signed(o_r)), 32704);
    check("r_max_valid",   int'(r_valid), 1);
    check("r_max_mono",    int'($signed(o_mono)), 16352);
    tick();
    check("r_valid_width", int'(r_valid), 0);

    // Most negative value on L.
    send_word(13'h1C00, 1'b0, 1'b1);
    check("l_min",       int'($signed(o_l)), -32768);
    check("l_min_valid", int'(l_valid), 1);
    check("l_min_mono",  int'($signed(o_mono)), -32);
    check("seq_ok_rl",   int'(seq_err), 0);
    tick();
    check("l_valid_width", int'(l_valid), 0);

    // Zero mantissa at e=1, and e=0 forcing zero.
    send_word(13'h0600, 1'b1, 1'b0);
    check("r_zero_e1",  int'($signed(o_r)), 0);
    check("mono_zero_r", int'($signed(o_mono)), -16384);
    send_word(13'h0155, 1'b0, 1'b1);
    check("l_zero_e0",  int'($signed(o_l)), 0);
    check("mono_zeros", int'($signed(o_mono)), 0);

    // R = 25 << 2, L = -301: mono rounds toward minus infinity.
    send_word(13'h0E19, 1'b1, 1'b0);
    check("r_100",    int'($signed(o_r)), 100);
    check("mono_50",  int'($signed(o_mono)), 50);
    send_word(13'h04D3, 1'b0, 1'b1);
    check("l_m301",    int'($signed(o_l)), -301);
    check("mono_m101", int'($signed(o_mono)), -101);

    // Both strobes fall together.
    send_word(13'h09FB, 1'b1, 1'b1);
    check("both_r",       int'($signed(o_r)), -10);
    check("both_l",       int'($signed(o_l)), -10);
    check("both_r_valid", int'(r_valid), 1);
    check("both_l_valid", int'(l_valid), 1);
    check("both_mono",    int'($signed(o_mono)), -10);
    check("both_seq_err", int'(seq_err), 0);

    // Two R captures in a row.
    send_word(13'h0664, 1'b1, 1'b0);
    check("rr_first_r",   int'($signed(o_r)), 100);
    check("rr_first_err", int'(seq_err), 0);
    check("rr_first_mono", int'($signed(o_mono)), 45);
    send_word(13'h0664, 1'b1, 1'b0);
    check("rr_second_err", int'(seq_err), 1);
    tick();
    tick();
    tick();
    check("rr_err_sticky", int'(seq_err), 1);
    seq_clr = 1'b1;
    tick();
    seq_clr = 1'b0;
    check("seq_clr", int'(seq_err), 0);

    // Bits loaded, then enable withheld while noise and strobe edge are presented.
    send_bits(13'h1207, 1'b0, 1'b1);
    ncen_n = 1'b1;
    sh2    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      so = 1'($urandom_range(0, 1));
      tick();
    end
    check("freeze_l",       int'($signed(o_l)), -10);
    check("freeze_l_valid", int'(l_valid), 0);
    check("freeze_r",       int'($signed(o_r)), 100);
    ncen_n = 1'b0;
    fall_and_update(1'b0, 1'b1);
    check("thaw_l",       int'($signed(o_l)), 56);
    check("thaw_l_valid", int'(l_valid), 1);
    check("thaw_mono",    int'($signed(o_mono)), 78);
    check("thaw_seq_err", int'(seq_err), 0);

    // Reset while the R strobe is high; strobe held low through release.
    send_word(13'h1FFF, 1'b1, 1'b0);
    check("pre_rst_r_valid", int'(r_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_r",       int'($signed(o_r)), 0);
    check("rst_mid_l",       int'($signed(o_l)), 0);
    check("rst_mid_mono",    int'($signed(o_mono)), 0);
    check("rst_mid_r_valid", int'(r_valid), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_r",       int'($signed(o_r)), 0);
    check("post_rst_r_valid", int'(r_valid), 0);
    check("post_rst_seq_err", int'(seq_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
